nor_stim_checker: RTL and testbench



---
 rtl/nor_check_pkg.sv | 23 ++
 rtl/settle_timer.sv | 38 +++
 rtl/nor_stim_checker.sv | 146 ++++++++++++++
 tb/tb_nor_stim_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nor_check_pkg.sv
// Shared types and constants for the NOR gate stimulus/checker blocks.
// Holds the FSM state encoding, default sizing and the golden NOR function.
package nor_check_pkg;

    localparam int unsigned N_IN_DEF       = 4;
    localparam int unsigned SETTLE_CYC_DEF = 2;
    localparam int unsigned CNT_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Golden N-input NOR over the low n bits of vec.
    function automatic logic golden_nor(input logic [31:0] vec, input int unsigned n);
        logic [31:0] mask;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return ~|(vec & mask);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable up/down counter with a terminal-count flag against a programmable value.
module settle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         down,
    input  logic [W-1:0] term_val,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = down ? (cnt_q - W'(1)) : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == term_val);

endmodule

// File: rtl/nor_stim_checker.sv
// Sweeps every input vector onto a NOR gate, waits a settle time, samples the
// gate output against the golden NOR and reports error count / first failure / pass.
module nor_stim_checker
    import nor_check_pkg::*;
#(
    parameter int unsigned N_IN       = N_IN_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

    localparam int unsigned ERR_W = N_IN + 1;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
    logic              fail_valid_q, fail_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_tc_c;
    logic              mism_c;

    settle_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val ('0),
        .en       (tmr_en),
        .down     (1'b0),
        .term_val (CNT_W'(SETTLE_CYC - 1)),
        .tc_c     (tmr_tc_c)
    );

    assign mism_c = (dut_out != golden_nor(32'(dut_in_q), N_IN));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        dut_in_d     = dut_in_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dut_in_d     = '0;
                    err_cnt_d    = '0;
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    tmr_load     = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_tc_c) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mism_c) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_vec_d   = dut_in_q;
                        fail_valid_d = 1'b1;
                    end
                end
                // Last vector ends the sweep; pass covers this final sample too.
                if (dut_in_q == '1) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = !fail_valid_q && !mism_c;
                    state_d = ST_DONE;
                end else begin
                    dut_in_d = dut_in_q + N_IN'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dut_in_q     <= '0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dut_in_q     <= dut_in_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign err_cnt    = err_cnt_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_nor_stim_checker.sv
// Bench for nor_stim_checker: a modelled NOR gate with selectable faults, checked
// against a sweep-level reference computed from the gate's truth table.
module tb_nor_stim_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy, done, pass, fail_valid;
    logic [4:0]  err_cnt;
    logic [3:0]  fail_vec;

    logic        start1;
    logic [3:0]  dut_in1;
    logic        dut_out1;
    logic        busy1, done1, pass1, fail_valid1;
    logic [4:0]  err_cnt1;
    logic [3:0]  fail_vec1;

    int          mode;
    logic [15:0] flip;
    int          n_tests;
    int          n_fail;

    nor_stim_checker #(.N_IN(4), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_vec(fail_vec), .fail_valid(fail_valid)
    );

    nor_stim_checker #(.N_IN(4), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
        .fail_vec(fail_vec1), .fail_valid(fail_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test: 0 good NOR, 1 stuck-0, 2 stuck-1, 3 OR, else NOR with per-vector flips.
    function automatic logic gate_model(input logic [3:0] v, input int m, input logic [15:0] fm);
        logic good;
        good = (v == 4'd0);
        case (m)
            0:       return good;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return !good;
            default: return good ^ fm[v];
        endcase
    endfunction

    always_comb dut_out  = gate_model(dut_in, mode, flip);
    always_comb dut_out1 = (dut_in1 == 4'd0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full sweep on the default instance, with optional ignored start pulses.
    task automatic run_sweep(input int m, input logic [15:0] fm, input bit repulse, input string tag);
        int       exp_err;
        int       exp_first;
        bit       found;
        mode = m;
        flip = fm;
        exp_err   = 0;
        exp_first = 0;
        found     = 1'b0;
        for (int v = 0; v < 16; v++) begin
            if (gate_model(4'(v), m, fm) != (v == 0)) begin
                exp_err++;
                if (!found) begin
                    exp_first = v;
                    found     = 1'b1;
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            check_eq({tag, "_vec"}, 32'(dut_in), 32'(k / 3));
            check_eq({tag, "_busydone"}, 32'({busy, done}), 32'(2'b10));
            start = repulse && (k == 15);
            @(negedge clk);
        end
        start = repulse;
        check_eq({tag, "_done"}, 32'({busy, done}), 32'(2'b01));
        check_eq({tag, "_lastvec"}, 32'(dut_in), 32'hF);
        check_eq({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_err));
        check_eq({tag, "_failvec"}, 32'(fail_vec), 32'(exp_first));
        check_eq({tag, "_failvalid"}, 32'(fail_valid), 32'(found));
        check_eq({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_donepulse"}, 32'(done), 32'd0);
        @(negedge clk);
        check_eq({tag, "_norestart"}, 32'({busy, done}), 32'd0);
        check_eq({tag, "_holdpass"}, 32'(pass), 32'(exp_err == 0));
        check_eq({tag, "_holderr"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        bit seen;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        start1  = 1'b0;
        mode    = 0;
        flip    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", 32'({dut_in, err_cnt, fail_vec, busy, done, pass, fail_valid}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(0, 16'h0, 1'b0, "good");
        run_sweep(1, 16'h0, 1'b0, "stuck0");
        run_sweep(2, 16'h0, 1'b0, "stuck1");
        run_sweep(3, 16'h0, 1'b0, "orgate");
        run_sweep(0, 16'h0, 1'b1, "repulse");

        // Reset mid-sweep at vector 7.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dut_in == 4'h7) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("reach_vec7", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("midrst_outs", 32'({dut_in, err_cnt, fail_vec, busy, done, pass, fail_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 55; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check_eq("midrst_quiet", 32'(seen), 32'd0);
        run_sweep(0, 16'h0, 1'b0, "afterrst");

        // start held high: restart at the first IDLE edge after DONE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        repeat (48) @(negedge clk);
        check_eq("hold_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("hold_idle", 32'({busy, done}), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("hold_restart", 32'({busy, dut_in}), 32'h10);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("hold_finish", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sweep(int'($urandom_range(0, 4)), 16'($urandom), 1'($urandom_range(0, 1)), "rnd");
        end

        // Single-cycle settle instance: 2 cycles per vector, done at T+32.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_eq("s1_vec", 32'(dut_in1), 32'(k / 2));
            check_eq("s1_done_early", 32'(done1), 32'd0);
            @(negedge clk);
        end
        check_eq("s1_done", 32'({busy1, done1}), 32'(2'b01));
        check_eq("s1_result", 32'({pass1, fail_valid1, err_cnt1, fail_vec1}), 32'h400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
